serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_arith_defs.vh | 9 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Types and helpers shared by the serial subtractor and its per-bit cell.
package serial_subtractor_pkg;

  `include "serial_arith_defs.vh"

  typedef enum logic [1:0] {
    StIdle = SER_ST_IDLE,
    StRun  = SER_ST_RUN,
    StDone = SER_ST_DONE
  } state_e;

  // One extra bit so the counter can never wrap within an operation.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational per-bit difference and borrow.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_arith_defs.vh
// Shared FSM state encodings for the serial arithmetic blocks (subtractor, future adder).
`ifndef SERIAL_ARITH_DEFS_VH
`define SERIAL_ARITH_DEFS_VH

localparam logic [1:0] SER_ST_IDLE = 2'd0;
localparam logic [1:0] SER_ST_RUN  = 2'd1;
localparam logic [1:0] SER_ST_DONE = 2'd2;

`endif

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;

  // Operands shift right so the current bit is always at position 0.
  full_subtractor u_full_subtractor (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state: capture on accept, one bit per RUN cycle, single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_bout;
        // Result bits enter at the MSB; after WIDTH shifts bit 0 lands at diff[0].
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          bout_d  = fs_bout;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at #1 after a posedge with the DUT idle. lat is the number of rising
  // edges after the accepting edge at which a synchronous consumer samples done=1.
  // Leaves at #1 after the edge that returns the DUT to IDLE.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_bin, output logic [W-1:0] r_diff,
                        output logic r_bout, output int lat);
    int n;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    bin   = op_bin;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after acceptance; they must not affect the result.
    a     = ~op_a;
    b     = ~op_b;
    bin   = ~op_bin;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat    = done ? n + 1 : -1;
    r_diff = diff;
    r_bout = bout;
    @(posedge clk); #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_bin, input logic [W-1:0] exp_diff, input logic exp_bout);
    logic [W-1:0] r_diff;
    logic         r_bout;
    int           lat;
    run_op(op_a, op_b, op_bin, r_diff, r_bout, lat);
    check({tag, "_diff"}, 32'(r_diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(r_bout), 32'(exp_bout));
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] r_diff;
    logic         r_bout;
    int           lat;
    int           pulses;
    logic [W-1:0] cap_diff;
    logic         cap_bout;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W:0]   ref_val;
    int           rand_err;
    int           n;

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(busy), 32'd0);

    directed("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    directed("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

    // Result must hold while idle even with inputs changing.
    a = 8'h5A; b = 8'hA5; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_diff", 32'(diff), 32'hFE);
    check("hold_bout", 32'(bout), 32'd1);

    directed("sub_00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    directed("sub_FF_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // start held high through RUN/DONE, operands changed mid-run.
    start = 1'b1; a = 8'h80; b = 8'h01; bin = 1'b0;
    @(posedge clk); #1;
    check("hold_start_busy", 32'(busy), 32'd1);
    pulses   = 0;
    cap_diff = '0;
    cap_bout = 1'b0;
    for (int e = 1; e <= W + 1; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        a = 8'h00;
        b = 8'h00;
      end
      if (done) begin
        pulses++;
        cap_diff = diff;
        cap_bout = bout;
      end
    end
    check("hold_start_pulses", 32'(pulses), 32'd1);
    check("hold_start_diff", 32'(cap_diff), 32'h7F);
    check("hold_start_bout", 32'(cap_bout), 32'd0);
    check("hold_start_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("hold_start_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("second_op_done", 32'(done), 32'd1);
    check("second_op_diff", 32'(diff), 32'h00);
    check("second_op_bout", 32'(bout), 32'd0);
    @(posedge clk); #1;

    // Reset while bit 4 is being processed.
    start = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_diff", 32'(diff), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("after_reset_quiet", 32'(pulses), 32'd0);

    // Random operations against the arithmetic reference.
    rand_err = 0;
    for (int i = 0; i < 1000; i++) begin
      ra      = W'($urandom);
      rb      = W'($urandom);
      rbin    = 1'($urandom);
      ref_val = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, r_diff, r_bout, lat);
      if (r_diff !== ref_val[W-1:0] || r_bout !== ref_val[W] || lat != W + 1) begin
        rand_err++;
        if (rand_err <= 5) begin
          check("rand_diff", 32'(r_diff), 32'(ref_val[W-1:0]));
          check("rand_bout", 32'(r_bout), 32'(ref_val[W]));
          check("rand_latency", 32'(lat), 32'(W + 1));
        end
      end
    end
    check("rand_error_count", 32'(rand_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
